nibble_serial_subtractor: RTL and testbench
===========================================

Name: nibble_serial_subtractor

Overview:
Multi-cycle unsigned subtractor that computes A - B one 4-bit slice per clock, least-significant nibble first, reusing a single 4-bit slice datapath. The slice adds A to the inverted B with an incoming carry, forming the borrow chain that complements our ripple-carry addition path.
It has an optional absolute-value pass that yields |A - B| plus a sign/borrow flag. This is the effective-subtraction path of the floating-point adder when operand signs differ. It sits between exponent alignment and normalisation, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 24, operand/result width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, derived count of nibbles (localparam, not overridable).

Ports:
clk  input  1  single clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands and abs_en present.
in_ready  output  1  block idle and able to accept operands.
a  input  WIDTH  minuend, unsigned.
b  input  WIDTH  subtrahend, unsigned.
abs_en  input  1  1 = return magnitude |A-B|; 0 = raw two's-complement A-B.
out_valid  output  1  result held stable.
out_ready  input  1  downstream accepts result.
diff  output  WIDTH  result.
borrow  output  1  1 when A < B (unsigned), independent of abs_en.
zero  output  1  1 when diff == 0.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE, idx 0, carry 1, diff 0, borrow 0, zero 0, out_valid 0. in_ready = 1 while in IDLE.
- States: IDLE, SUB, NEG, DONE.
- in_ready is 1 only in IDLE. Accept occurs when in_valid && in_ready.
- In IDLE on accept: latch a, b and abs_en; idx <= 0; carry <= 1; diff <= 0; go to SUB.
- SUB, one nibble k=idx per cycle:
  - {c, s} = a[k] + ~b[k] + carry (4-bit slice, 5-bit result).
  - diff[k] <= s; carry <= c; idx <= idx+1.
  - After nibble NIB-1: borrow <= ~c_final.
  - If abs_en_q && ~c_final: go to NEG with idx 0 and carry 1.
  - Otherwise go to DONE.
- NEG, one nibble per cycle: {c, s} = ~diff[k] + carry; diff[k] <= s; carry <= c. After nibble NIB-1, go to DONE. borrow is unchanged.
- DONE:
  - out_valid = 1; zero = (diff == 0), registered on entry.
  - diff, borrow and zero are held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE and drop out_valid in the same edge. in_ready rises in the following cycle; no same-cycle turnaround.
- Latency from the accepting edge to out_valid high:
  - NIB cycles when abs_en=0 or A>=B.
  - 2*NIB cycles when abs_en=1 and A<B.
- in_valid outside IDLE is ignored; operands are not re-sampled.
- Input a/b changes after acceptance have no effect.
- A == B: diff 0, borrow 0, zero 1, no NEG pass.
- Wrap-around: idx counts 0..NIB-1 and resets to 0 at each phase start. No out-of-range nibble select.
- rst_n asserted mid SUB/NEG/DONE: the operation is aborted, the result is discarded and all outputs return to their reset values immediately.
- Outputs are driven only from registers and state, with no combinational path from inputs to outputs. The exception is in_ready, which is decoded from state.

Test Plan:
- WIDTH=8, a=0x93, b=0x25, abs_en=0 -> out_valid 2 cycles after accept; diff=0x6E, borrow=0, zero=0.
- WIDTH=8, a=0x25, b=0x93, abs_en=0 -> diff=0x92, borrow=1, latency 2. Repeat with abs_en=1 -> diff=0x6E, borrow=1, latency 4.
- WIDTH=8, a=b=0x5A, abs_en=1 -> diff=0x00, borrow=0, zero=1, latency 2.
- Default WIDTH=24, a=0x000001, b=0x000002, abs_en=1 -> diff=0x000001, borrow=1, latency 12. Then a=0xFFFFFF, b=0 -> diff=0xFFFFFF, latency 6.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff/borrow/zero stable, in_ready=0. Toggle a/b and pulse in_valid meanwhile -> ignored. out_ready=1 -> IDLE, in_ready=1 next cycle.
- Assert rst_n=0 during the 3rd SUB cycle (WIDTH=24) -> out_valid=0, diff=0, in_ready=1 at once. A new operation afterwards gives the correct result.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Serial unsigned subtractor: one 4-bit slice per clock, LS nibble first, with an
// optional second pass that negates a negative result to give |A - B|.
module nibble_serial_subtractor #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abs_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_upd;
  logic             abs_q, carry, borrow_q, zero_q;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    base;
  logic             last;
  logic [4:0]       sub_sum, neg_sum;

  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIB - 1));

  // Shared slice: A + ~B + carry while subtracting, ~D + carry while negating.
  always_comb begin
    sub_sum    = {1'b0, a_q[base +: 4]} + {1'b0, ~b_q[base +: 4]} + {4'b0000, carry};
    neg_sum    = {1'b0, ~diff_q[base +: 4]} + {4'b0000, carry};
    diff_upd   = diff_q;
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = SUB;
      SUB: begin
        diff_upd[base +: 4] = sub_sum[3:0];
        if (last) state_next = (abs_q && !sub_sum[4]) ? NEG : DONE;
      end
      NEG: begin
        diff_upd[base +: 4] = neg_sum[3:0];
        if (last) state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      abs_q    <= 1'b0;
      idx      <= '0;
      carry    <= 1'b1;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q    <= a;
          b_q    <= b;
          abs_q  <= abs_en;
          idx    <= '0;
          carry  <= 1'b1;
          diff_q <= '0;
        end
        SUB: begin
          diff_q <= diff_upd;
          carry  <= sub_sum[4];
          if (last) begin
            idx      <= '0;
            borrow_q <= ~sub_sum[4];
            if (state_next == NEG) carry <= 1'b1;
            else zero_q <= (diff_upd == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        NEG: begin
          diff_q <= diff_upd;
          carry  <= neg_sum[4];
          if (last) begin
            idx    <= '0;
            zero_q <= (diff_upd == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor at WIDTH=8 and the default WIDTH=24.
module tb_nibble_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid8 = 1'b0, in_ready8, abs_en8 = 1'b0, out_valid8, out_ready8 = 1'b0;
  logic        borrow8, zero8;
  logic [7:0]  a8 = '0, b8 = '0, diff8;
  logic        in_valid24 = 1'b0, in_ready24, abs_en24 = 1'b0, out_valid24, out_ready24 = 1'b0;
  logic        borrow24, zero24;
  logic [23:0] a24 = '0, b24 = '0, diff24;

  int tests = 0;
  int fails = 0;

  nibble_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .abs_en(abs_en8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .borrow(borrow8), .zero(zero8)
  );

  nibble_serial_subtractor dut24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid24), .in_ready(in_ready24),
    .a(a24), .b(b24), .abs_en(abs_en24), .out_valid(out_valid24), .out_ready(out_ready24),
    .diff(diff24), .borrow(borrow24), .zero(zero24)
  );

  // Accept one operation and count edges until out_valid; result is left held in DONE.
  task automatic apply_stimulus8(input logic [7:0] av, input logic [7:0] bv, input logic ab,
                                 output int lat);
    a8 = av; b8 = bv; abs_en8 = ab; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 999;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (out_valid8) begin lat = i; break; end
    end
  endtask

  task automatic apply_stimulus24(input logic [23:0] av, input logic [23:0] bv, input logic ab,
                                  output int lat);
    a24 = av; b24 = bv; abs_en24 = ab; in_valid24 = 1'b1;
    @(posedge clk); #1;
    in_valid24 = 1'b0;
    lat = 999;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (out_valid24) begin lat = i; break; end
    end
  endtask

  task automatic pop8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic pop24();
    out_ready24 = 1'b1;
    @(posedge clk); #1;
    out_ready24 = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (out_valid8 !== 1'b0) begin fails++; $display("[TB] FAIL reset8 out_valid got %b want 0", out_valid8); end
    tests++; if (in_ready8 !== 1'b1) begin fails++; $display("[TB] FAIL reset8 in_ready got %b want 1", in_ready8); end
    tests++; if ({diff8, borrow8, zero8} !== 10'd0) begin fails++; $display("[TB] FAIL reset8 diff/borrow/zero got %h/%b/%b want 0", diff8, borrow8, zero8); end
    tests++; if (out_valid24 !== 1'b0 || in_ready24 !== 1'b1) begin fails++; $display("[TB] FAIL reset24 valid/ready got %b/%b want 0/1", out_valid24, in_ready24); end
    tests++; if ({diff24, borrow24, zero24} !== 26'd0) begin fails++; $display("[TB] FAIL reset24 diff/borrow/zero got %h/%b/%b want 0", diff24, borrow24, zero24); end
  endtask

  task automatic test_sub8();
    int lat;
    apply_stimulus8(8'h93, 8'h25, 1'b0, lat);
    tests++; if (lat !== 2) begin fails++; $display("[TB] FAIL sub8_pos latency got %0d want 2", lat); end
    tests++; if ({diff8, borrow8, zero8} !== {8'h6E, 1'b0, 1'b0}) begin fails++; $display("[TB] FAIL sub8_pos diff/borrow/zero got %h/%b/%b want 6e/0/0", diff8, borrow8, zero8); end
    pop8();
    apply_stimulus8(8'h25, 8'h93, 1'b0, lat);
    tests++; if (lat !== 2) begin fails++; $display("[TB] FAIL sub8_neg latency got %0d want 2", lat); end
    tests++; if ({diff8, borrow8, zero8} !== {8'h92, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL sub8_neg diff/borrow/zero got %h/%b/%b want 92/1/0", diff8, borrow8, zero8); end
    pop8();
  endtask

  task automatic test_abs8();
    int lat;
    apply_stimulus8(8'h25, 8'h93, 1'b1, lat);
    tests++; if (lat !== 4) begin fails++; $display("[TB] FAIL abs8 latency got %0d want 4", lat); end
    tests++; if ({diff8, borrow8, zero8} !== {8'h6E, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL abs8 diff/borrow/zero got %h/%b/%b want 6e/1/0", diff8, borrow8, zero8); end
    pop8();
  endtask

  task automatic test_equal8();
    int lat;
    apply_stimulus8(8'h5A, 8'h5A, 1'b1, lat);
    tests++; if (lat !== 2) begin fails++; $display("[TB] FAIL equal8 latency got %0d want 2", lat); end
    tests++; if ({diff8, borrow8, zero8} !== {8'h00, 1'b0, 1'b1}) begin fails++; $display("[TB] FAIL equal8 diff/borrow/zero got %h/%b/%b want 00/0/1", diff8, borrow8, zero8); end
    pop8();
  endtask

  task automatic test_wide24();
    int lat;
    apply_stimulus24(24'h000001, 24'h000002, 1'b1, lat);
    tests++; if (lat !== 12) begin fails++; $display("[TB] FAIL wide24_abs latency got %0d want 12", lat); end
    tests++; if ({diff24, borrow24, zero24} !== {24'h000001, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL wide24_abs diff/borrow/zero got %h/%b/%b want 000001/1/0", diff24, borrow24, zero24); end
    pop24();
    apply_stimulus24(24'hFFFFFF, 24'h000000, 1'b1, lat);
    tests++; if (lat !== 6) begin fails++; $display("[TB] FAIL wide24_max latency got %0d want 6", lat); end
    tests++; if ({diff24, borrow24, zero24} !== {24'hFFFFFF, 1'b0, 1'b0}) begin fails++; $display("[TB] FAIL wide24_max diff/borrow/zero got %h/%b/%b want ffffff/0/0", diff24, borrow24, zero24); end
    pop24();
  endtask

  task automatic test_backpressure();
    int lat;
    apply_stimulus8(8'h93, 8'h25, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'h11 * i[7:0]; b8 = 8'hF0 - 8'(i); in_valid8 = i[0];
      @(posedge clk); #1;
      tests++; if ({out_valid8, in_ready8, diff8, borrow8, zero8} !== {1'b1, 1'b0, 8'h6E, 1'b0, 1'b0}) begin
        fails++; $display("[TB] FAIL hold cycle %0d valid/ready/diff/borrow/zero got %b/%b/%h/%b/%b want 1/0/6e/0/0",
                          i, out_valid8, in_ready8, diff8, borrow8, zero8);
      end
    end
    in_valid8 = 1'b0;
    pop8();
    tests++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin fails++; $display("[TB] FAIL release valid/ready got %b/%b want 0/1", out_valid8, in_ready8); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    a24 = 24'hABCDEF; b24 = 24'h123456; abs_en24 = 1'b0; in_valid24 = 1'b1;
    @(posedge clk); #1;
    in_valid24 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++; if ({out_valid24, in_ready24, diff24, borrow24, zero24} !== {1'b0, 1'b1, 24'h0, 1'b0, 1'b0}) begin
      fails++; $display("[TB] FAIL abort valid/ready/diff/borrow/zero got %b/%b/%h/%b/%b want 0/1/000000/0/0",
                        out_valid24, in_ready24, diff24, borrow24, zero24);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    apply_stimulus24(24'h123456, 24'h654321, 1'b1, lat);
    tests++; if (lat !== 12) begin fails++; $display("[TB] FAIL after_abort latency got %0d want 12", lat); end
    tests++; if ({diff24, borrow24, zero24} !== {24'h530ECB, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL after_abort diff/borrow/zero got %h/%b/%b want 530ecb/1/0", diff24, borrow24, zero24); end
    pop24();
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_sub8();
    test_abs8();
    test_equal8();
    test_wide24();
    test_backpressure();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
